// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - pipelined SLL/SRL/SRA barrel shifter with valid/ready and pass-through tag
// Optional rotate-right on op 11 when SHIFT_ROTATE_EN is defined; otherwise op 11 is SRL.
module shift_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int L = $clog2(WIDTH);

  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic [1:0]       op_q    [STAGES];
  logic [1:0]       op_d    [STAGES];
  logic [L-1:0]     sh_q    [STAGES];
  logic [L-1:0]     sh_d    [STAGES];
  logic [WIDTH-1:0] data_q  [STAGES];
  logic [WIDTH-1:0] data_d  [STAGES];
  logic [TAG_W-1:0] tag_q   [STAGES];
  logic [TAG_W-1:0] tag_d   [STAGES];

  logic advance;
  logic unused_bits;

  // First barrel level owned by stage i: ceil(i*L/STAGES).
  function automatic int level_lo(input int i);
    return (i * L + STAGES - 1) / STAGES;
  endfunction

  function automatic logic [WIDTH-1:0] shift_level(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input int               amt
  );
    logic [WIDTH-1:0] r;
    r = d;
    case (op)
      2'b00: r = d << amt;
      2'b10: r = $unsigned($signed(d) >>> amt);
`ifdef SHIFT_ROTATE_EN
      2'b01: r = d >> amt;
      2'b11: r = (d >> amt) | (d << (WIDTH - amt));
`else
      2'b01, 2'b11: r = d >> amt;
`endif
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] stage_shift(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic [L-1:0]     sh,
    input int               stage
  );
    logic [WIDTH-1:0] r;
    r = d;
    for (int k = 0; k < L; k++) begin
      if (k >= level_lo(stage) && k < level_lo(stage + 1) && sh[k])
        r = shift_level(r, op, 1 << k);
    end
    return r;
  endfunction

  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign unused_bits = ^{in_b[WIDTH-1:L], op_q[STAGES-1], sh_q[STAGES-1]};

  always_comb begin
    advance  = !valid_q[STAGES-1] || out_ready;
    in_ready = advance && !flush;
    for (int i = 0; i < STAGES; i++) begin
      valid_d[i] = valid_q[i];
      op_d[i]    = op_q[i];
      sh_d[i]    = sh_q[i];
      data_d[i]  = data_q[i];
      tag_d[i]   = tag_q[i];
    end
    // One global stall: every stage moves together or none does.
    if (advance) begin
      valid_d[0] = in_valid && in_ready;
      op_d[0]    = in_op;
      sh_d[0]    = in_b[L-1:0];
      tag_d[0]   = in_tag;
      data_d[0]  = stage_shift(in_a, in_op, in_b[L-1:0], 0);
      for (int i = 1; i < STAGES; i++) begin
        valid_d[i] = valid_q[i-1];
        op_d[i]    = op_q[i-1];
        sh_d[i]    = sh_q[i-1];
        tag_d[i]   = tag_q[i-1];
        data_d[i]  = stage_shift(data_q[i-1], op_q[i-1], sh_q[i-1], i);
      end
    end
    if (flush) begin
      for (int i = 0; i < STAGES; i++) valid_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        valid_q[i] <= 1'b0;
        op_q[i]    <= 2'b00;
        sh_q[i]    <= '0;
        data_q[i]  <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        valid_q[i] <= valid_d[i];
        op_q[i]    <= op_d[i];
        sh_q[i]    <= sh_d[i];
        data_q[i]  <= data_d[i];
        tag_q[i]   <= tag_d[i];
      end
    end
  end

endmodule
